// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between the CPU core and the peripheral/DMA port.
// One transaction at a time: IDLE -> ACCESS -> WAIT (MEM_LAT cycles) -> ACK -> IDLE.
module mem_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MEM_LAT  = 1,
  parameter int CPU_PRIO = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          per_req,
  input  logic          per_we,
  input  logic [AW-1:0] per_addr,
  input  logic [DW-1:0] per_wdata,
  output logic          per_ack,
  output logic [DW-1:0] per_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_t        state_q, state_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          per_ack_q, per_ack_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] per_rdata_q, per_rdata_d;
  logic          owner_q, owner_d;
  logic          last_owner_q, last_owner_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          grant_per;

  // Fixed priority lets the CPU starve the peripheral; round-robin breaks ties against the last owner.
  always_comb begin
    if (CPU_PRIO != 0) begin
      grant_per = !cpu_req;
    end else if (cpu_req && per_req) begin
      grant_per = !last_owner_q;
    end else begin
      grant_per = per_req;
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_en_d     = mem_en_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_ack_d    = 1'b0;
    per_ack_d    = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    per_rdata_d  = per_rdata_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (cpu_req || per_req) begin
          state_d      = ACCESS;
          mem_en_d     = 1'b1;
          owner_d      = grant_per;
          last_owner_d = grant_per;
          mem_we_d     = grant_per ? per_we    : cpu_we;
          mem_addr_d   = grant_per ? per_addr  : cpu_addr;
          mem_wdata_d  = grant_per ? per_wdata : cpu_wdata;
        end
      end
      ACCESS: begin
        mem_en_d = 1'b0;
        cnt_d    = LAT;
        state_d  = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ACK;
          if (owner_q) begin
            per_ack_d = 1'b1;
          end else begin
            cpu_ack_d = 1'b1;
          end
          // Writes leave both read-data registers untouched.
          if (!mem_we_q) begin
            if (owner_q) begin
              per_rdata_d = mem_rdata;
            end else begin
              cpu_rdata_d = mem_rdata;
            end
          end
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_ack_q    <= 1'b0;
      per_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      per_rdata_q  <= '0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      cnt_q        <= 4'd0;
    end else begin
      state_q      <= state_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_ack_q    <= cpu_ack_d;
      per_ack_q    <= per_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      per_rdata_q  <= per_rdata_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign per_ack   = per_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign per_rdata = per_rdata_q;
  assign owner     = owner_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: DUT 0 is round-robin with MEM_LAT=3, DUT 1 is CPU-priority with MEM_LAT=1.
// Each DUT has its own latency-accurate memory model that returns filler data outside the valid cycle.
module tb_mem_port_arbiter;

  localparam int LAT0 = 3;
  localparam int LAT1 = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req [2];
  logic        cpu_we [2];
  logic [31:0] cpu_addr [2];
  logic [31:0] cpu_wdata [2];
  logic        cpu_ack [2];
  logic [31:0] cpu_rdata [2];
  logic        per_req [2];
  logic        per_we [2];
  logic [31:0] per_addr [2];
  logic [31:0] per_wdata [2];
  logic        per_ack [2];
  logic [31:0] per_rdata [2];
  logic        mem_en [2];
  logic        mem_we [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic        busy [2];
  logic        owner [2];

  logic [31:0] mem [2][256];
  logic [31:0] pipe0 [3];
  logic [31:0] pipe1;
  logic        pl_en = 1'b0;
  logic        pl_dut = 1'b0;
  logic [7:0]  pl_addr = 8'd0;
  logic [31:0] pl_data = 32'd0;

  int checks = 0;
  int errors = 0;
  int g_own [8];
  int g_cyc [8];

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT0), .CPU_PRIO(0)) u_rr (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]),
    .cpu_ack(cpu_ack[0]), .cpu_rdata(cpu_rdata[0]),
    .per_req(per_req[0]), .per_we(per_we[0]), .per_addr(per_addr[0]), .per_wdata(per_wdata[0]),
    .per_ack(per_ack[0]), .per_rdata(per_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .busy(busy[0]), .owner(owner[0])
  );

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT1), .CPU_PRIO(1)) u_fp (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]),
    .cpu_ack(cpu_ack[1]), .cpu_rdata(cpu_rdata[1]),
    .per_req(per_req[1]), .per_we(per_we[1]), .per_addr(per_addr[1]), .per_wdata(per_wdata[1]),
    .per_ack(per_ack[1]), .per_rdata(per_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .busy(busy[1]), .owner(owner[1])
  );

  // Read data appears exactly MEM_LAT cycles after the mem_en cycle.
  always @(posedge clk) begin
    if (pl_en) mem[pl_dut][pl_addr] <= pl_data;
    if (mem_en[0] && mem_we[0]) mem[0][mem_addr[0][7:0]] <= mem_wdata[0];
    if (mem_en[1] && mem_we[1]) mem[1][mem_addr[1][7:0]] <= mem_wdata[1];
    pipe0[0] <= (mem_en[0] && !mem_we[0]) ? mem[0][mem_addr[0][7:0]] : 32'hBAD0_BAD0;
    pipe0[1] <= pipe0[0];
    pipe0[2] <= pipe0[1];
    pipe1    <= (mem_en[1] && !mem_we[1]) ? mem[1][mem_addr[1][7:0]] : 32'hBAD1_BAD1;
  end

  assign mem_rdata[0] = pipe0[2];
  assign mem_rdata[1] = pipe1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int latv(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  task automatic preload(input logic d, input logic [7:0] a, input logic [31:0] v);
    @(negedge clk);
    pl_en = 1'b1; pl_dut = d; pl_addr = a; pl_data = v;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic drive(input int d, input bit per, input bit req, input bit we,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (per) begin
      per_req[d] = req; per_we[d] = we; per_addr[d] = addr; per_wdata[d] = wd;
    end else begin
      cpu_req[d] = req; cpu_we[d] = we; cpu_addr[d] = addr; cpu_wdata[d] = wd;
    end
  endtask

  // One transaction from one requester; chg swaps the address to alt during the ACCESS cycle.
  task automatic xfer(input int d, input bit per, input bit we, input logic [31:0] addr,
                      input logic [31:0] wd, input bit chg, input logic [31:0] alt, input string tag);
    int cyc = 0;
    int ack_cyc = -1;
    int en_cyc = -1;
    int en_cnt = 0;
    int other_ack = 0;
    logic [31:0] l_addr = 32'd0;
    logic [31:0] l_wd = 32'd0;
    logic l_we = 1'b0;
    drive(d, per, 1'b1, we, addr, wd);
    while (ack_cyc < 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1 && chg) drive(d, per, 1'b1, we, alt, wd);
      if (mem_en[d]) begin
        en_cnt++; en_cyc = cyc; l_addr = mem_addr[d]; l_we = mem_we[d]; l_wd = mem_wdata[d];
      end
      if (per ? cpu_ack[d] : per_ack[d]) other_ack++;
      if (per ? per_ack[d] : cpu_ack[d]) ack_cyc = cyc;
    end
    check({tag, "_ack_cycle"}, ack_cyc, latv(d) + 2);
    check({tag, "_en_cycle"}, en_cyc, 1);
    check({tag, "_en_count"}, en_cnt, 1);
    check({tag, "_mem_addr"}, l_addr, addr);
    check({tag, "_mem_we"}, l_we, we);
    check({tag, "_mem_wdata"}, l_wd, wd);
    check({tag, "_other_ack"}, other_ack, 0);
    check({tag, "_addr_hold"}, mem_addr[d], addr);
    drive(d, per, 1'b0, we, per ? per_addr[d] : cpu_addr[d], wd);
    @(negedge clk);
    check({tag, "_idle_busy"}, busy[d], 1'b0);
    check({tag, "_ack_low"}, per ? per_ack[d] : cpu_ack[d], 1'b0);
  endtask

  // Both requesters held high; the CPU drops its request after cpu_stop acks (0 = never).
  task automatic run_both(input int d, input int ngrant, input int cpu_stop);
    int g = 0;
    int cyc = 0;
    int cacks = 0;
    int done = 0;
    cpu_req[d] = 1'b1;
    per_req[d] = 1'b1;
    while (g < ngrant && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (mem_en[d]) begin
        g_own[g] = int'(owner[d]); g_cyc[g] = cyc; g++;
      end
      if (cpu_ack[d]) begin
        cacks++;
        if (cacks == cpu_stop) cpu_req[d] = 1'b0;
      end
    end
    check("grants_seen", g, ngrant);
    while (done == 0 && cyc < 260) begin
      @(negedge clk);
      cyc++;
      if (cpu_ack[d] || per_ack[d]) done = 1;
    end
    check("drain_ack", done, 1);
    cpu_req[d] = 1'b0;
    per_req[d] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    for (int d = 0; d < 2; d++) begin
      drive(d, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      drive(d, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    end
    preload(1'b1, 8'h10, 32'hDEAD_BEEF);
    preload(1'b1, 8'h30, 32'hCAFE_F00D);
    preload(1'b0, 8'h40, 32'h0A0A_0A0A);
    preload(1'b0, 8'h44, 32'h0B0B_0B0B);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst%0d_mem_en", d), mem_en[d], 1'b0);
      check($sformatf("rst%0d_mem_addr", d), mem_addr[d], 32'd0);
      check($sformatf("rst%0d_busy", d), busy[d], 1'b0);
      check($sformatf("rst%0d_rdata", d), {cpu_rdata[d], per_rdata[d]}, 64'd0);
      check($sformatf("rst%0d_acks", d), {cpu_ack[d], per_ack[d], owner[d]}, 3'b000);
    end

    // CPU-priority DUT, MEM_LAT=1
    xfer(1, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, "cpu_rd10");
    check("cpu_rd10_rdata", cpu_rdata[1], 32'hDEAD_BEEF);
    check("cpu_rd10_per_rdata", per_rdata[1], 32'd0);
    xfer(1, 1'b0, 1'b0, 32'h30, 32'h0, 1'b0, 32'h0, "cpu_rd30");
    check("cpu_rd30_rdata", cpu_rdata[1], 32'hCAFE_F00D);
    xfer(1, 1'b0, 1'b0, 32'h10, 32'h0, 1'b1, 32'h30, "addr_chg");
    check("addr_chg_rdata", cpu_rdata[1], 32'hDEAD_BEEF);

    drive(1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
    drive(1, 1'b1, 1'b0, 1'b0, 32'h30, 32'h0);
    run_both(1, 5, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fp_owner%0d", i), g_own[i], 0);
      check($sformatf("fp_cycle%0d", i), g_cyc[i], 1 + 4 * i);
    end
    check("fp_owner4", g_own[4], 1);
    check("fp_cycle4", g_cyc[4], 17);
    check("fp_per_rdata", per_rdata[1], 32'hCAFE_F00D);

    // Round-robin DUT, MEM_LAT=3
    xfer(0, 1'b1, 1'b1, 32'h20, 32'h1234_5678, 1'b0, 32'h0, "per_wr20");
    check("per_wr20_per_rdata", per_rdata[0], 32'd0);
    check("per_wr20_cpu_rdata", cpu_rdata[0], 32'd0);
    xfer(0, 1'b0, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0, "cpu_rd20");
    check("cpu_rd20_rdata", cpu_rdata[0], 32'h1234_5678);

    // Reset pulse in the middle of WAIT
    drive(0, 1'b0, 1'b1, 1'b0, 32'h20, 32'h5555_5555);
    repeat (3) @(negedge clk);
    check("midrst_busy_before", busy[0], 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy[0], 1'b0);
    check("midrst_mem_addr", mem_addr[0], 32'd0);
    check("midrst_mem_wdata", mem_wdata[0], 32'd0);
    check("midrst_cpu_rdata", cpu_rdata[0], 32'd0);
    check("midrst_ctl", {mem_en[0], mem_we[0], cpu_ack[0], per_ack[0], owner[0]}, 5'b00000);
    #1;
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0);
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      if (cpu_ack[0] || per_ack[0]) acks++;
    end
    check("midrst_no_ack", acks, 0);

    drive(0, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0);
    drive(0, 1'b1, 1'b0, 1'b0, 32'h44, 32'h0);
    run_both(0, 4, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr_owner%0d", i), g_own[i], i % 2);
      check($sformatf("rr_cycle%0d", i), g_cyc[i], 1 + 6 * i);
    end
    check("rr_cpu_rdata", cpu_rdata[0], 32'h0A0A_0A0A);
    check("rr_per_rdata", per_rdata[0], 32'h0B0B_0B0B);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
